// File: rtl/id_redirect_if.sv
// id_redirect_if: bundle between the fetch side and the IF/ID redirect unit.
// Ports (signals):
//   inst, next_addr, rs_data, rt_data            -> unit : fetched word, PC+4, regfile reads
//   ex_regWrite, ex_memRead, ex_dst              -> unit : hazard info from EX
//   mem_memRead, mem_dst                         -> unit : hazard info from MEM
//   PCWrite, pcSrc, isJ, branch_addr, j_addr     <- unit : PC control back to IF
//   id_inst, id_next_addr, id_valid, id_bubble   <- unit : IF/ID register and bubble flag
//   stall_cnt, flush_cnt                         <- unit : saturating event counters
// Modports: slave = the redirect unit, master = whatever drives IF/EX/MEM info.
interface id_redirect_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      inst;
  logic [31:0]      next_addr;
  logic [31:0]      rs_data;
  logic [31:0]      rt_data;
  logic             ex_regWrite;
  logic             ex_memRead;
  logic [4:0]       ex_dst;
  logic             mem_memRead;
  logic [4:0]       mem_dst;
  logic             PCWrite;
  logic             pcSrc;
  logic             isJ;
  logic [31:0]      branch_addr;
  logic [25:0]      j_addr;
  logic [31:0]      id_inst;
  logic [31:0]      id_next_addr;
  logic             id_valid;
  logic             id_bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  inst, next_addr, rs_data, rt_data,
           ex_regWrite, ex_memRead, ex_dst, mem_memRead, mem_dst,
    output PCWrite, pcSrc, isJ, branch_addr, j_addr,
           id_inst, id_next_addr, id_valid, id_bubble, stall_cnt, flush_cnt
  );

  modport master (
    output inst, next_addr, rs_data, rt_data,
           ex_regWrite, ex_memRead, ex_dst, mem_memRead, mem_dst,
    input  PCWrite, pcSrc, isJ, branch_addr, j_addr,
           id_inst, id_next_addr, id_valid, id_bubble, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/id_redirect_unit.sv
// id_redirect_unit: IF/ID pipeline register plus ID-stage branch/jump resolution.
// Resolves beq/bne/j/jal/jr in ID, drives PCWrite/pcSrc/isJ/branch_addr/j_addr to
// fetch, holds IF/ID on load-use and branch-data hazards, and replaces the single
// wrong-path fetch with NOP_INST on a redirect.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : id_redirect_if.slave (see interface header for the signal list)
// Parameters:
//   NOP_INST : word loaded into IF/ID on flush/reset
//   CNT_W    : width of the saturating stall/flush counters (must match bus)
module id_redirect_unit #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  id_redirect_if.slave  bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  logic [31:0]      id_inst_q,      id_inst_d;
  logic [31:0]      id_next_addr_q, id_next_addr_d;
  logic             id_valid_q,     id_valid_d;
  logic [CNT_W-1:0] stall_cnt_q,    stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q,    flush_cnt_d;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imm;
  logic        is_beq, is_bne, is_j, is_jal, is_jr;
  logic        is_br, uses_rt;
  logic        load_use, ex_br_haz, mem_br_haz;
  logic        stall, taken, jump, redirect;

  // Decode of the instruction held in IF/ID.
  always_comb begin
    op      = id_inst_q[31:26];
    rs      = id_inst_q[25:21];
    rt      = id_inst_q[20:16];
    imm     = id_inst_q[15:0];
    is_beq  = (op == OP_BEQ);
    is_bne  = (op == OP_BNE);
    is_j    = (op == OP_J);
    is_jal  = (op == OP_JAL);
    is_jr   = (op == OP_RTYPE) && (id_inst_q[5:0] == FN_JR);
    is_br   = is_beq || is_bne;
    uses_rt = is_br || ((op == OP_RTYPE) && !is_jr) || (op == OP_SW);
  end

  // Hazards: a load in EX blocks any consumer; branches/jr compare in ID, so they
  // additionally wait on an ALU result in EX and on a load still in MEM.
  always_comb begin
    load_use   = bus.ex_memRead && (bus.ex_dst != 5'd0) &&
                 ((bus.ex_dst == rs) || (uses_rt && (bus.ex_dst == rt)));
    ex_br_haz  = (is_br || is_jr) && bus.ex_regWrite && (bus.ex_dst != 5'd0) &&
                 ((bus.ex_dst == rs) || (is_br && (bus.ex_dst == rt)));
    mem_br_haz = (is_br || is_jr) && bus.mem_memRead && (bus.mem_dst != 5'd0) &&
                 ((bus.mem_dst == rs) || (is_br && (bus.mem_dst == rt)));
    stall      = id_valid_q && (load_use || ex_br_haz || mem_br_haz);
    taken      = id_valid_q && !stall &&
                 ((is_beq && (bus.rs_data == bus.rt_data)) ||
                  (is_bne && (bus.rs_data != bus.rt_data)) ||
                  is_jr);
    jump       = id_valid_q && !stall && (is_j || is_jal);
    redirect   = taken || jump;
  end

  always_comb begin
    bus.PCWrite      = !stall;
    bus.pcSrc        = taken;
    bus.isJ          = jump;
    bus.branch_addr  = is_jr ? bus.rs_data
                             : id_next_addr_q + {{14{imm[15]}}, imm, 2'b00};
    bus.j_addr       = id_inst_q[25:0];
    bus.id_inst      = id_inst_q;
    bus.id_next_addr = id_next_addr_q;
    bus.id_valid     = id_valid_q;
    bus.id_bubble    = stall || !id_valid_q;
    bus.stall_cnt    = stall_cnt_q;
    bus.flush_cnt    = flush_cnt_q;
  end

  // IF/ID update: stall holds everything, redirect squashes the wrong-path fetch.
  always_comb begin
    id_inst_d      = id_inst_q;
    id_next_addr_d = id_next_addr_q;
    id_valid_d     = id_valid_q;
    stall_cnt_d    = stall_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    if (stall) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else if (redirect) begin
      id_inst_d      = NOP_INST;
      id_next_addr_d = bus.next_addr;
      id_valid_d     = 1'b0;
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      id_inst_d      = bus.inst;
      id_next_addr_d = bus.next_addr;
      id_valid_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_inst_q      <= NOP_INST;
      id_next_addr_q <= '0;
      id_valid_q     <= 1'b0;
      stall_cnt_q    <= '0;
      flush_cnt_q    <= '0;
    end else begin
      id_inst_q      <= id_inst_d;
      id_next_addr_q <= id_next_addr_d;
      id_valid_q     <= id_valid_d;
      stall_cnt_q    <= stall_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

endmodule
